// File: rtl/lut_layer_sequencer_pkg.sv
// lut_seq_pkg: shared types and constants for the LUT layer sequencer.
// Holds the sequencer FSM state encoding, the neuron geometry (6-input
// neurons with 64-bit truth tables) and the truth-table lookup helper.
package lut_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Inputs per neuron and truth-table size (2**FANIN entries).
  localparam int FANIN      = 6;
  localparam int TABLE_BITS = 64;

  // Selects one of the FANIN inputs of a neuron.
  typedef logic [2:0] fanin_idx_t;

  // Address formed by the FANIN address bits of a neuron.
  typedef logic [FANIN-1:0] lut_addr_t;

  // Truth-table read: returns the table entry selected by addr.
  function automatic logic lut_lookup(input logic [TABLE_BITS-1:0] tbl,
                                      input lut_addr_t             addr);
    return tbl[addr];
  endfunction

endpackage

// File: rtl/lut_layer_sequencer_if.sv
// lut_seq_if: input-vector / output-result handshake bundle of the LUT
// layer sequencer. The sequencer uses the slave modport; the producer /
// consumer side uses the master modport.
interface lut_seq_if #(
  parameter int IN_WIDTH    = 16,
  parameter int NUM_NEURONS = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_data;
  logic                   busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/lut_layer_sequencer_table.sv
// lut_seq_table: per-neuron truth table and fan-in storage with a
// combinational read by neuron index.
// Optional feature macro: LUT_SEQ_CFG_WRITE_EN. When defined the contents
// live in registers loaded from TABLE_INIT/FANIN_INIT on reset and a write
// port updates one neuron per cycle; otherwise the contents are the
// parameter constants and the module is purely combinational.
module lut_seq_table
  import lut_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IDX_W       = 4,
  parameter int NEUR_W      = 3,
  parameter logic [NUM_NEURONS*TABLE_BITS-1:0]  TABLE_INIT = '0,
  parameter logic [NUM_NEURONS*FANIN*IDX_W-1:0] FANIN_INIT = '0
) (
`ifdef LUT_SEQ_CFG_WRITE_EN
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [NEUR_W-1:0]        wr_neuron_i,
  input  logic [TABLE_BITS-1:0]    wr_table_i,
  input  logic [FANIN*IDX_W-1:0]   wr_fanin_i,
`endif
  input  logic [NEUR_W-1:0]        rd_neuron_i,
  output logic [TABLE_BITS-1:0]    rd_table_o,
  output logic [FANIN*IDX_W-1:0]   rd_fanin_o
);

`ifdef LUT_SEQ_CFG_WRITE_EN
  logic [TABLE_BITS-1:0]  table_q [NUM_NEURONS];
  logic [FANIN*IDX_W-1:0] fanin_q [NUM_NEURONS];

  // Reload contents from the parameters on reset; apply configuration writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        table_q[n] <= TABLE_INIT[n*TABLE_BITS +: TABLE_BITS];
        fanin_q[n] <= FANIN_INIT[n*FANIN*IDX_W +: FANIN*IDX_W];
      end
    end else if (wr_en_i && (32'(wr_neuron_i) < NUM_NEURONS)) begin
      table_q[wr_neuron_i] <= wr_table_i;
      fanin_q[wr_neuron_i] <= wr_fanin_i;
    end else begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        table_q[n] <= table_q[n];
        fanin_q[n] <= fanin_q[n];
      end
    end
  end

  // Combinational read of the selected neuron's table and fan-in.
  always_comb begin
    rd_table_o = table_q[rd_neuron_i];
    rd_fanin_o = fanin_q[rd_neuron_i];
  end
`else
  // Combinational read of the selected neuron straight from the constants.
  always_comb begin
    rd_table_o = TABLE_INIT[32'(rd_neuron_i)*TABLE_BITS +: TABLE_BITS];
    rd_fanin_o = FANIN_INIT[32'(rd_neuron_i)*FANIN*IDX_W +: FANIN*IDX_W];
  end
`endif

endmodule

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: evaluates one layer of 6-input LUT neurons, one
// neuron per clock, over a captured input vector.
// Flow: IDLE accepts a vector, EVAL walks neurons 0..NUM_NEURONS-1 writing
// one result bit per cycle, DONE presents the result until it is consumed.
// Optional feature macro: LUT_SEQ_CFG_WRITE_EN adds the cfg_* write port
// for updating a neuron's table and fan-in while IDLE.
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int NUM_NEURONS = 8,
  parameter int IN_WIDTH    = 16,
  localparam int IDX_W      = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1,
  localparam int NEUR_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  parameter logic [NUM_NEURONS*TABLE_BITS-1:0]  TABLE_INIT = '0,
  parameter logic [NUM_NEURONS*FANIN*IDX_W-1:0] FANIN_INIT = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef LUT_SEQ_CFG_WRITE_EN
  input  logic                   cfg_we,
  input  logic [NEUR_W-1:0]      cfg_neuron,
  input  logic [TABLE_BITS-1:0]  cfg_table,
  input  logic [FANIN*IDX_W-1:0] cfg_fanin,
`endif
  lut_seq_if.slave               bus
);

  localparam logic [NEUR_W-1:0] LAST_NEURON = NEUR_W'(NUM_NEURONS - 1);

  seq_state_e             state_q, state_d;
  logic [NEUR_W-1:0]      cnt_q, cnt_d;
  logic [IN_WIDTH-1:0]    in_q, in_d;
  logic [NUM_NEURONS-1:0] out_q, out_d;

  logic [TABLE_BITS-1:0]  tbl_s;
  logic [FANIN*IDX_W-1:0] fan_s;
  lut_addr_t              addr_s;
  logic                   cfg_wr_s;
  logic                   in_ready_s;

`ifdef LUT_SEQ_CFG_WRITE_EN
  // Configuration writes only take effect while no pass is in flight.
  assign cfg_wr_s = cfg_we && (state_q == ST_IDLE);

  lut_seq_table #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NEUR_W      (NEUR_W),
    .TABLE_INIT  (TABLE_INIT),
    .FANIN_INIT  (FANIN_INIT)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (cfg_wr_s),
    .wr_neuron_i (cfg_neuron),
    .wr_table_i  (cfg_table),
    .wr_fanin_i  (cfg_fanin),
    .rd_neuron_i (cnt_q),
    .rd_table_o  (tbl_s),
    .rd_fanin_o  (fan_s)
  );
`else
  assign cfg_wr_s = 1'b0;

  lut_seq_table #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IDX_W),
    .NEUR_W      (NEUR_W),
    .TABLE_INIT  (TABLE_INIT),
    .FANIN_INIT  (FANIN_INIT)
  ) u_table (
    .rd_neuron_i (cnt_q),
    .rd_table_o  (tbl_s),
    .rd_fanin_o  (fan_s)
  );
`endif

  // Gather the current neuron's address bits; indices past the input width read 0.
  always_comb begin
    addr_s = '0;
    for (int i = 0; i < FANIN; i++) begin
      if (32'(fan_s[i*IDX_W +: IDX_W]) < IN_WIDTH) begin
        addr_s[i] = in_q[fan_s[i*IDX_W +: IDX_W]];
      end else begin
        addr_s[i] = 1'b0;
      end
    end
  end

  // FSM next state, neuron counter, input capture and result bit update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    in_d       = in_q;
    out_d      = out_q;
    in_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = ~cfg_wr_s;
        if (bus.in_valid && in_ready_s) begin
          in_d    = bus.in_data;
          cnt_d   = '0;
          state_d = ST_EVAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        out_d[cnt_q] = lut_lookup(tbl_s, addr_s);
        if (cnt_q == LAST_NEURON) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_EVAL;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// Self-checking bench for lut_layer_sequencer: random vectors compared
// against a truth-table model, plus latency, hold, abort and
// out-of-range fan-in cases. The DUT uses IN_WIDTH=12 so that 4-bit
// fan-in indices 12..15 are representable and lie beyond the input width.
`timescale 1ns/1ps
module tb_lut_layer_sequencer;
  import lut_seq_pkg::*;

  localparam int NN  = 8;
  localparam int IW  = 12;
  localparam int IXW = 4;

  localparam logic [NN*64-1:0] TBL = {
    64'h0000_0000_0000_000A, 64'h8000_0000_0000_0000,
    64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000,
    64'h0F0F_3C3C_A5A5_6996, 64'h8000_0000_0000_0001,
    64'hDEAD_BEEF_0123_4567, 64'h55FF_FFFF_0000_0000
  };
  // Per neuron, slots 5..0 (slot 0 is the address LSB); neuron 0 is rightmost.
  localparam logic [NN*6*IXW-1:0] FAN =
    192'hFEDC10_777777_0C5A3F_FEDCBA_13579B_02468A_BA9876_543210;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_seq_if #(.IN_WIDTH(IW), .NUM_NEURONS(NN)) bus ();

`ifdef LUT_SEQ_CFG_WRITE_EN
  logic        cfg_we;
  logic [2:0]  cfg_neuron;
  logic [63:0] cfg_table;
  logic [23:0] cfg_fanin;
`endif

  lut_layer_sequencer #(
    .NUM_NEURONS (NN),
    .IN_WIDTH    (IW),
    .TABLE_INIT  (TBL),
    .FANIN_INIT  (FAN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef LUT_SEQ_CFG_WRITE_EN
    .cfg_we     (cfg_we),
    .cfg_neuron (cfg_neuron),
    .cfg_table  (cfg_table),
    .cfg_fanin  (cfg_fanin),
`endif
    .bus        (bus)
  );

  // Reference model state: the tables and fan-ins the DUT should hold.
  logic [63:0]   m_tbl [NN];
  int            m_fan [NN][6];
  logic [NN-1:0] last_out;
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int n = 0; n < NN; n++) begin
      m_tbl[n] = TBL[64*n +: 64];
      for (int i = 0; i < 6; i++) m_fan[n][i] = int'(FAN[(6*n+i)*IXW +: IXW]);
    end
  endtask

  // Layer result: each neuron looks up its table at the 6-bit address
  // formed from the selected input bits (out-of-range index -> 0).
  function automatic logic [NN-1:0] model(input logic [IW-1:0] d);
    logic [NN-1:0] res;
    int addr;
    res = '0;
    for (int n = 0; n < NN; n++) begin
      addr = 0;
      for (int i = 0; i < 6; i++)
        if (m_fan[n][i] < IW && d[m_fan[n][i]]) addr += (1 << i);
      res[n] = m_tbl[n][addr];
    end
    return res;
  endfunction

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    model_reset();
    check_eq("reset_state", {bus.out_valid, bus.busy, bus.in_ready, bus.out_data},
             {1'b0, 1'b0, 1'b1, {NN{1'b0}}});
    rst_n = 1'b1;
  endtask

  // One full pass: accept, count latency, check result, hold, handshake.
  task automatic run_vector(input logic [IW-1:0] d, input int hold);
    logic [NN-1:0] exp;
    int lat;
    int bad_ready;
    exp = model(d);
    check_eq("idle_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    check_eq("accept_busy", {bus.busy, bus.in_ready}, 2'b10);
    lat = 0;
    bad_ready = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_data  = IW'($urandom);
      bus.in_valid = 1'($urandom_range(0, 1));
      step();
      lat++;
      if (bus.in_ready) bad_ready++;
    end
    bus.in_valid = 1'b0;
    check_eq("latency", lat, NN);
    check_eq("ready_low_in_pass", bad_ready, 0);
    check_eq("result", bus.out_data, exp);
    last_out = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      bus.in_data = IW'($urandom);
      step();
      check_eq("hold", {bus.out_valid, bus.in_ready, bus.out_data}, {1'b1, 1'b0, exp});
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_eq("back_to_idle", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
  endtask

  initial begin
    int seen;
    logic [IW-1:0] d;
`ifdef LUT_SEQ_CFG_WRITE_EN
    int lat;
    cfg_we     = 1'b0;
    cfg_neuron = '0;
    cfg_table  = '0;
    cfg_fanin  = '0;
`endif
    last_out = '0;
    do_reset();

    // Neuron 0 worked example: address 57 -> 0, address 56 -> 1.
    run_vector(12'h039, 0);
    check_eq("n0_addr57", last_out[0], 0);
    run_vector(12'h038, 5);
    check_eq("n0_addr56", last_out[0], 1);

    // Neuron 7 only sees bits 0 and 1; indices 12..15 read as 0 -> address 3.
    run_vector(12'hFFF, 1);
    check_eq("oob_fanin", last_out[7], 1);

    // Reset while neuron 3 is being evaluated aborts the pass.
    bus.in_valid = 1'b1;
    bus.in_data  = IW'($urandom);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    check_eq("abort_state", {bus.out_valid, bus.busy, bus.in_ready, bus.out_data},
             {1'b0, 1'b0, 1'b1, {NN{1'b0}}});
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.out_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    run_vector(IW'($urandom), 1);

    // Randomized passes with random back-pressure.
    for (int v = 0; v < 25; v++) begin
      d = IW'($urandom);
      run_vector(d, $urandom_range(0, 3));
    end

`ifdef LUT_SEQ_CFG_WRITE_EN
    // A write attempted during EVAL must not change the tables.
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    step();
    bus.in_valid = 1'b0;
    step();
    cfg_we     = 1'b1;
    cfg_neuron = 3'd2;
    cfg_table  = 64'h1;
    cfg_fanin  = '0;
    step();
    cfg_we = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    check_eq("cfg_eval_ignored", bus.out_data, model('0));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    // A write in IDLE blocks acceptance for that cycle and updates neuron 2.
    cfg_we       = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = '0;
    check_eq("cfg_blocks_ready", bus.in_ready, 0);
    step();
    cfg_we       = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("cfg_no_accept", {bus.busy, bus.in_ready}, 2'b01);
    m_tbl[2] = 64'h1;
    for (int i = 0; i < 6; i++) m_fan[2][i] = 0;
    run_vector('0, 1);
    check_eq("cfg_n2_written", last_out[2], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
